// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//   Load/store controller between the pipeline memory stage and dmemory.
//   It accepts one request at a time over a valid/ready handshake. Each
//   request is checked for range, size and alignment before it reaches memory.
//   The controller drives dmemory's combinational-read / clocked-write port
//   and returns load data or an error on a one-cycle response strobe.
//
//   Optional feature: define LSU_MISALIGN_SPLIT_EN to split misaligned
//   in-range half/word requests into byte accesses. When the macro is
//   undefined, those requests fault with no memory access.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   req_valid/ready     request handshake; ready is high only in IDLE
//   req_write           0 load, 1 store
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_signed          sign-extend the load result
//   req_addr, req_wdata byte address; store data, LSB-aligned
//   resp_valid          one-cycle completion strobe
//   resp_rdata          load result; 0 for stores and errors
//   resp_error          range, alignment or size fault
//   mem_*               dmemory port (address, data_in, read_write,
//                       access_size, is_signed, data_out)
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter logic [31:0] MEM_BASE = 32'h0100_0000,
    parameter logic [31:0] MEM_SIZE = 32'd1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic        mem_is_signed,
    input  logic [31:0] mem_data_out
);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd3
    } state_t;
`endif

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    state_t      state;

    // Latched request
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    // ------------------------------------------------------------------
    // Request classification (on the live request, used only in IDLE)
    // ------------------------------------------------------------------
    logic [32:0] req_bytes;
    logic [32:0] req_last;
    logic [32:0] mem_limit;
    logic        size_fault;
    logic        range_fault;
    logic        misaligned;

    always_comb begin
        case (req_size)
            SIZE_BYTE: req_bytes = 33'd1;
            SIZE_HALF: req_bytes = 33'd2;
            default:   req_bytes = 33'd4;
        endcase
        // 33-bit arithmetic so a request near 0xFFFF_FFFF cannot wrap
        // back into the valid window.
        req_last    = {1'b0, req_addr} + req_bytes - 33'd1;
        mem_limit   = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
        size_fault  = (req_size == SIZE_BAD);
        range_fault = (req_addr < MEM_BASE) || (req_last >= mem_limit);
        misaligned  = ((req_size == SIZE_HALF) && req_addr[0]) ||
                      ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // ------------------------------------------------------------------
    // Byte-split datapath
    // ------------------------------------------------------------------
    logic [1:0]  byte_cnt;
    logic [23:0] split_buf;      // load bytes 0..2; the final byte comes straight from memory
    logic        split_last;
    logic [7:0]  split_wbyte;
    logic [15:0] split_half;
    logic [31:0] split_result;

    always_comb begin
        split_last = (lat_size == SIZE_HALF) ? (byte_cnt == 2'd1) : (byte_cnt == 2'd3);
        case (byte_cnt)
            2'd0:    split_wbyte = lat_wdata[7:0];
            2'd1:    split_wbyte = lat_wdata[15:8];
            2'd2:    split_wbyte = lat_wdata[23:16];
            default: split_wbyte = lat_wdata[31:24];
        endcase
        split_half = {mem_data_out[7:0], split_buf[7:0]};
        if (lat_size == SIZE_HALF) begin
            split_result = lat_signed ? {{16{split_half[15]}}, split_half}
                                      : {16'h0000, split_half};
        end else begin
            split_result = {mem_data_out[7:0], split_buf};
        end
    end
`endif

    // ------------------------------------------------------------------
    // Memory port: decoded from the state register so an asynchronous
    // reset drops read_write immediately. Outside an access the port sits
    // on a harmless in-range word read at MEM_BASE.
    // ------------------------------------------------------------------
    always_comb begin
        mem_address     = MEM_BASE;
        mem_data_in     = '0;
        mem_read_write  = 1'b0;
        mem_access_size = SIZE_WORD;
        mem_is_signed   = 1'b0;
        case (state)
            ACCESS: begin
                mem_address     = lat_addr;
                mem_data_in     = lat_wdata;
                mem_read_write  = lat_write;
                mem_access_size = lat_size;
                mem_is_signed   = lat_signed;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
                mem_address     = lat_addr + {30'b0, byte_cnt};
                mem_data_in     = {24'b0, split_wbyte};
                mem_read_write  = lat_write;
                mem_access_size = SIZE_BYTE;
                mem_is_signed   = 1'b0;
            end
`endif
            default: begin
                mem_address     = MEM_BASE;
                mem_data_in     = '0;
                mem_read_write  = 1'b0;
                mem_access_size = SIZE_WORD;
                mem_is_signed   = 1'b0;
            end
        endcase
    end

    assign req_ready = (state == IDLE);

    // ------------------------------------------------------------------
    // Control FSM with registered response outputs. The response fields
    // default to zero every cycle, so they are non-zero only while
    // resp_valid is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_write  <= 1'b0;
            lat_size   <= '0;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            byte_cnt   <= '0;
            split_buf  <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        if (size_fault || range_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else if (misaligned) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                            state     <= SPLIT;
                            byte_cnt  <= '0;
                            split_buf <= '0;
`else
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
`endif
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // dmemory already sized and extended the read data.
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= lat_write ? '0 : mem_data_out;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                SPLIT: begin
                    if (!lat_write) begin
                        case (byte_cnt)
                            2'd0:    split_buf[7:0]   <= mem_data_out[7:0];
                            2'd1:    split_buf[15:8]  <= mem_data_out[7:0];
                            2'd2:    split_buf[23:16] <= mem_data_out[7:0];
                            default: split_buf        <= split_buf;
                        endcase
                    end
                    if (split_last) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= lat_write ? '0 : split_result;
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
`endif
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_ctrl;

    localparam logic [31:0] MEM_BASE = 32'h0100_0000;
    localparam logic [31:0] MEM_SIZE = 32'd1048576;
    localparam int unsigned WIN      = 4096;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic        mem_is_signed;
    logic [31:0] mem_data_out;

    logic        mem_init;
    logic [7:0]  dmem    [0:WIN-1];
    logic [7:0]  ref_mem [0:WIN-1];
    logic [31:0] dm_word;

    int n_cmp  = 0;
    int n_fail = 0;

    lsu_ctrl #(.MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_read_write (mem_read_write),
        .mem_access_size(mem_access_size),
        .mem_is_signed  (mem_is_signed),
        .mem_data_out   (mem_data_out)
    );

    always #5 clock = ~clock;

    // Window index: the bench memory aliases every 4 KiB of the data space.
    function automatic int unsigned widx(input logic [31:0] a);
        logic [31:0] d;
        d = a - MEM_BASE;
        return {20'b0, d[11:0]};
    endfunction

    // dmemory stand-in: combinational little-endian read, clocked write.
    always_comb begin
        dm_word = {dmem[widx(mem_address + 32'd3)], dmem[widx(mem_address + 32'd2)],
                   dmem[widx(mem_address + 32'd1)], dmem[widx(mem_address)]};
        case (mem_access_size)
            2'b00:   mem_data_out = mem_is_signed ? {{24{dm_word[7]}}, dm_word[7:0]} : {24'b0, dm_word[7:0]};
            2'b01:   mem_data_out = mem_is_signed ? {{16{dm_word[15]}}, dm_word[15:0]} : {16'b0, dm_word[15:0]};
            default: mem_data_out = dm_word;
        endcase
    end

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < WIN; i++) dmem[i] <= 8'(i * 37 + 5);
        end else if (mem_read_write) begin
            dmem[widx(mem_address)] <= mem_data_in[7:0];
            if (mem_access_size != 2'b00) dmem[widx(mem_address + 32'd1)] <= mem_data_in[15:8];
            if (mem_access_size[1]) begin
                dmem[widx(mem_address + 32'd2)] <= mem_data_in[23:16];
                dmem[widx(mem_address + 32'd3)] <= mem_data_in[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int unsigned nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_fault(input logic [1:0] s, input logic [31:0] a);
        longint unsigned last, lim;
        last = {32'b0, a} + 64'(nbytes(s)) - 64'd1;
        lim  = {32'b0, MEM_BASE} + {32'b0, MEM_SIZE};
        return (s == 2'b11) || (a < MEM_BASE) || (last >= lim);
    endfunction

    function automatic bit model_misaligned(input logic [1:0] s, input logic [31:0] a);
        return ((s == 2'b01) && a[0]) || ((s == 2'b10) && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] s, input logic sg, input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < int'(nbytes(s)); i++)
            v = v | (32'(ref_mem[widx(a + 32'(i))]) << (8 * i));
        if (sg && s == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
        if (sg && s == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_port(input string tag);
        check({tag, ".idle_addr"}, mem_address, MEM_BASE);
        check({tag, ".idle_rw"},   32'(mem_read_write), 32'd0);
        check({tag, ".idle_size"}, 32'(mem_access_size), 32'd2);
        check({tag, ".idle_sgn"},  32'(mem_is_signed), 32'd0);
        check({tag, ".idle_din"},  mem_data_in, 32'd0);
    endtask

    // One request: predict outcome, drive it, record the memory port per
    // cycle until resp_valid, then compare everything against the model.
    task automatic do_req(input string tag, input logic w, input logic [1:0] s,
                          input logic sg, input logic [31:0] a, input logic [31:0] d);
        bit          flt, mis, split;
        int unsigned n, exp_lat, lat;
        logic [31:0] exp_rd, got_rd;
        logic        got_err, got_rdy;
        logic [31:0] r_addr [0:7];
        logic [31:0] r_din  [0:7];
        logic        r_rw   [0:7];
        logic        r_sg   [0:7];
        logic [1:0]  r_sz   [0:7];

        flt = model_fault(s, a);
        mis = model_misaligned(s, a);
`ifdef LSU_MISALIGN_SPLIT_EN
        split = !flt && mis;
`else
        split = 1'b0;
        if (mis) flt = 1'b1;
`endif
        n       = nbytes(s);
        exp_lat = flt ? 1 : (split ? n + 1 : 2);
        exp_rd  = (flt || w) ? 32'h0 : model_load(s, sg, a);

        @(negedge clock);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = s;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        @(posedge clock);
        #1 req_valid = 1'b0;

        lat = 0;
        got_rd = '0; got_err = 1'b0; got_rdy = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            r_addr[c-1] = mem_address;
            r_din[c-1]  = mem_data_in;
            r_rw[c-1]   = mem_read_write;
            r_sg[c-1]   = mem_is_signed;
            r_sz[c-1]   = mem_access_size;
            if (resp_valid) begin
                lat = c; got_rd = resp_rdata; got_err = resp_error; got_rdy = req_ready;
                break;
            end
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".error"}, 32'(got_err), 32'(flt));
        check({tag, ".rdata"}, got_rd, exp_rd);
        check({tag, ".ready_in_resp"}, 32'(got_rdy), 32'd0);

        if (lat != 0) begin
            for (int i = 0; i + 1 < int'(lat); i++) begin
                check({tag, ".acc_addr"}, r_addr[i], split ? a + 32'(i) : a);
                check({tag, ".acc_rw"},   32'(r_rw[i]), 32'(w));
                check({tag, ".acc_size"}, 32'(r_sz[i]), split ? 32'd0 : 32'(s));
                check({tag, ".acc_sgn"},  32'(r_sg[i]), split ? 32'd0 : 32'(sg));
                if (w) begin
                    if (split) check({tag, ".acc_byte"}, 32'(r_din[i][7:0]), (d >> (8 * i)) & 32'hFF);
                    else       check({tag, ".acc_din"},  r_din[i], d);
                end
            end
            check({tag, ".resp_addr"}, r_addr[lat-1], MEM_BASE);
            check({tag, ".resp_rw"},   32'(r_rw[lat-1]), 32'd0);
        end

        @(negedge clock);
        check({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ".post_rdata"}, resp_rdata, 32'd0);
        check({tag, ".post_error"}, 32'(resp_error), 32'd0);

        if (w && !flt)
            for (int i = 0; i < int'(n); i++) ref_mem[widx(a + 32'(i))] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [1:0]  s;
        int unsigned r;
        int          seen;

        reset = 1'b1; mem_init = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < WIN; i++) ref_mem[i] = 8'(i * 37 + 5);

        @(negedge clock); mem_init = 1'b1;
        @(negedge clock); mem_init = 1'b0;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.valid", 32'(resp_valid), 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.error", 32'(resp_error), 32'd0);
        check_idle_port("rst");
        reset = 1'b0;
        @(negedge clock);
        check_idle_port("after_rst");

        // Aligned word and byte traffic
        do_req("st_w",  1'b1, 2'b10, 1'b0, MEM_BASE + 32'h10, 32'hDEAD_BEEF);
        do_req("ld_w",  1'b0, 2'b10, 1'b0, MEM_BASE + 32'h10, 32'h0);
        do_req("st_b",  1'b1, 2'b00, 1'b0, MEM_BASE + 32'h10, 32'h0000_0080);
        do_req("ld_bs", 1'b0, 2'b00, 1'b1, MEM_BASE + 32'h10, 32'h0);
        do_req("ld_bu", 1'b0, 2'b00, 1'b0, MEM_BASE + 32'h10, 32'h0);
        do_req("ld_hs", 1'b0, 2'b01, 1'b1, MEM_BASE + 32'h10, 32'h0);

        // Range and size faults, plus the last valid bytes
        do_req("f_low",   1'b0, 2'b10, 1'b0, 32'h00FF_FFFC, 32'h0);
        do_req("f_end",   1'b0, 2'b10, 1'b0, MEM_BASE + MEM_SIZE - 32'd2, 32'h0);
        do_req("f_size",  1'b1, 2'b11, 1'b0, MEM_BASE, 32'h1234_5678);
        do_req("f_wrap",  1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
        do_req("f_pastb", 1'b1, 2'b00, 1'b0, MEM_BASE + MEM_SIZE, 32'h55);
        do_req("ok_lastb", 1'b1, 2'b00, 1'b0, MEM_BASE + MEM_SIZE - 32'd1, 32'h5A);
        do_req("ok_lastw", 1'b0, 2'b10, 1'b0, MEM_BASE + MEM_SIZE - 32'd4, 32'h0);

        // Misaligned traffic (split or fault depending on the build)
        do_req("mis_stw", 1'b1, 2'b10, 1'b0, MEM_BASE + 32'h21, 32'h1122_3344);
        do_req("mis_ldw", 1'b0, 2'b10, 1'b0, MEM_BASE + 32'h21, 32'h0);
        do_req("mis_ldh", 1'b0, 2'b01, 1'b1, MEM_BASE + 32'h23, 32'h0);
        do_req("mis_h01", 1'b0, 2'b01, 1'b0, MEM_BASE + 32'h01, 32'h0);
        do_req("mis_sth", 1'b1, 2'b01, 1'b0, MEM_BASE + 32'h31, 32'h0000_8001);
        do_req("mis_lhs", 1'b0, 2'b01, 1'b1, MEM_BASE + 32'h31, 32'h0);

        // Randomized mix
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            s = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            r = $urandom_range(0, 9);
            if (r == 0)      a = MEM_BASE - 32'($urandom_range(1, 4));
            else if (r == 1) a = MEM_BASE + MEM_SIZE - 32'($urandom_range(1, 6));
            else             a = MEM_BASE + 32'($urandom_range(0, 63));
            d = $urandom;
            do_req("rnd", 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, d);
        end

        // Reset during an aligned store's ACCESS cycle: nothing is written.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = MEM_BASE + 32'h40; req_wdata = 32'hA5A5_A5A5;
        @(posedge clock);
        #1 req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_acc.rw", 32'(mem_read_write), 32'd0);
        check("rst_acc.ready", 32'(req_ready), 32'd1);
        check("rst_acc.addr", mem_address, MEM_BASE);
        @(negedge clock); reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        check("rst_acc.no_resp", 32'(seen), 32'd0);
        do_req("rst_acc.ld", 1'b0, 2'b10, 1'b0, MEM_BASE + 32'h40, 32'h0);

`ifdef LSU_MISALIGN_SPLIT_EN
        // Reset during the third byte of a split store: bytes 0..1 persist.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = MEM_BASE + 32'h51; req_wdata = 32'hCAFE_F00D;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3;
        check("rst_split.addr_k2", mem_address, MEM_BASE + 32'h53);
        reset = 1'b1;
        #1;
        check("rst_split.rw", 32'(mem_read_write), 32'd0);
        check("rst_split.ready", 32'(req_ready), 32'd1);
        check("rst_split.valid", 32'(resp_valid), 32'd0);
        @(negedge clock); reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        check("rst_split.no_resp", 32'(seen), 32'd0);
        ref_mem[widx(MEM_BASE + 32'h51)] = 8'h0D;
        ref_mem[widx(MEM_BASE + 32'h52)] = 8'hF0;
        for (int i = 0; i < 4; i++)
            do_req("rst_split.ld", 1'b0, 2'b00, 1'b0, MEM_BASE + 32'h51 + 32'(i), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the pipeline memory stage and `dmemory`. Accepts one load or store request at a time over a valid/ready handshake. Checks range and alignment, then drives `dmemory`'s combinational-read / clocked-write port, splitting misaligned accesses into byte accesses when enabled. Returns load data or an error flag on a one-cycle response strobe.

## Interface
- `MEM_BASE`, 32'h0100_0000, first valid data address
- `MEM_SIZE`, 32'd1048576, bytes of data memory; must match `` `MEM_DEPTH``
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept; high only in IDLE
- `req_write`  in  1  0 load, 1 store
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_signed`  in  1  sign-extend load result
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, LSB-aligned
- `resp_valid`  out  1  one-cycle completion strobe, no backpressure
- `resp_rdata`  out  32  load result; 0 for stores and errors
- `resp_error`  out  1  range, alignment or size fault; valid with `resp_valid`
- `mem_address`  out  32  to `dmemory.address`
- `mem_data_in`  out  32  to `dmemory.data_in`
- `mem_read_write`  out  1  to `dmemory.read_write`
- `mem_access_size`  out  2  to `dmemory.access_size`
- `mem_is_signed`  out  1  to `dmemory.is_signed`
- `mem_data_out`  in  32  from `dmemory.data_out`

## Operation
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch the request and classify it:
  - Fault: size 11, `req_addr` < `MEM_BASE`, or `req_addr`+bytes-1 ≥ `MEM_BASE`+`MEM_SIZE` (33-bit compare; no wrap). Goes to RESP with error.
  - Aligned: goes to ACCESS.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0): goes to SPLIT with the macro on, otherwise to RESP with error.
- ACCESS, one cycle:
  - Drives the latched address, size and signed flag, with `mem_read_write`=`req_write`.
  - Loads capture `mem_data_out` at the closing edge. Stores are written by `dmemory` at that edge.
  - Goes to RESP.
- SPLIT, N cycles (N=2 half, 4 word); byte counter k=0..N-1:
  - Drives `mem_address`=addr+k, `mem_access_size`=00, `mem_is_signed`=0 and `mem_data_in`[7:0]=wdata[8k+7:8k].
  - Loads place `mem_data_out`[7:0] into result byte k.
  - After k=N-1, sign- or zero-extends from bit 15 (half) or passes 32 bits (word), then goes to RESP.
- RESP, one cycle: `resp_valid`=1, then back to IDLE. A new request is not accepted in RESP.
- Outside ACCESS/SPLIT, memory outputs are: `mem_address`=`MEM_BASE`, `mem_read_write`=0, `mem_access_size`=10, `mem_is_signed`=0, `mem_data_in`=0.
  - Keeps `dmemory`'s every-edge range check from firing when idle.
  - A faulted request never reaches memory.
- `mem_read_write` is decoded from the state register, so an asynchronous reset deasserts it immediately.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, memory outputs at the idle values above.
- Acceptance at edge E0.
  - Aligned: ACCESS in cycle 1, `resp_valid` in cycle 2.
  - Misaligned: SPLIT in cycles 1..N, `resp_valid` in cycle N+1.
  - Fault: `resp_valid` in cycle 1.
- Throughput: at most one request per 3 cycles when aligned.
- `resp_rdata`/`resp_error` are registered, valid only while `resp_valid`=1, and return to 0 otherwise.
- Reset mid-SPLIT store:
  - Bytes already written stay written.
  - No response is produced.
  - The request is dropped.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: misaligned in-range half/word requests are split into byte accesses as above.
- Undefined: they fault with `resp_error`=1, with no memory access, and the SPLIT state and byte counter are not compiled.

## Test plan
- Aligned word store 0xDEADBEEF to 0x0100_0010, then load word -> `resp_rdata`=0xDEADBEEF, `resp_error`=0, `resp_valid` 2 cycles after acceptance.
- Byte load signed/unsigned from 0x0100_0010 after storing byte 0x80 -> 0xFFFF_FF80 signed, 0x0000_0080 unsigned.
- Load at 0x00FF_FFFC and word at `MEM_BASE`+`MEM_SIZE`-2 -> `resp_error`=1, `resp_rdata`=0, `mem_read_write` never 1, `mem_address` stays 0x0100_0000.
- With the macro: word store 0x11223344 to 0x0100_0021 takes 4 SPLIT cycles with addresses 0x21..0x24 and bytes 44,33,22,11; a load back returns 0x11223344. Half load from 0x0100_0023 of bytes 0x22,0x11 with signed=1 -> 0x00001122.
- Without the macro: half load from 0x0100_0001 -> `resp_error`=1 one cycle after acceptance.
- Assert `reset` during SPLIT cycle 2 of a word store -> `mem_read_write`=0 immediately, `req_ready`=1, no `resp_valid`; only bytes 0..1 are modified.
